// File: rtl/safety_monitor.sv
// Telemetry conditioner for the piezo driver: persistence/hysteresis battery flag,
// held over-speed flag and a debounced-entry rider mode FSM. All outputs registered.
module safety_monitor #(
  parameter logic [11:0] BATT_THRES = 12'h800,
  parameter logic [11:0] BATT_HYST  = 12'h040,
  parameter int unsigned PERSIST    = 4,
  parameter logic [11:0] SPD_THRES  = 12'd1536,
  parameter logic [23:0] HOLD_CYC   = 24'd10_000_000,
  parameter logic [15:0] ENTRY_CYC  = 16'd50_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pwr_up,
  input  logic        en_steer,
  input  logic [11:0] batt,
  input  logic        batt_vld,
  input  logic [11:0] lft_spd,
  input  logic [11:0] rght_spd,
  input  logic        spd_vld,
  output logic        norm_mode,
  output logic        ovr_spd,
  output logic        batt_low
);

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_ARMED  = 2'd1,
    ST_NORMAL = 2'd2
  } state_t;

  localparam logic [3:0]  PERSIST_M1 = 4'(PERSIST - 1);
  localparam logic [12:0] BATT_HI    = {1'b0, BATT_THRES} + {1'b0, BATT_HYST};

  // Two's-complement magnitude; -2048 has no positive twin and saturates.
  function automatic logic [11:0] sat_abs(input logic [11:0] v);
    logic [11:0] r;
    if (v == 12'h800) begin
      r = 12'h7FF;
    end else if (v[11]) begin
      r = 12'd0 - v;
    end else begin
      r = v;
    end
    return r;
  endfunction

  state_t      state_r, state_s;
  logic [15:0] ecnt_r, ecnt_s;
  logic        norm_mode_r;
  logic [3:0]  pcnt_r, pcnt_s;
  logic        batt_low_r, batt_low_s;
  logic        batt_qual_s;
  logic [23:0] hold_r, hold_s;
  logic        ovr_spd_r, ovr_spd_s;
  logic [11:0] lft_mag_s, rght_mag_s, mag_s;
  logic        over_s;

  // Target condition flips with the current flag to give hysteresis.
  assign batt_qual_s = batt_low_r ? ({1'b0, batt} >= BATT_HI) : (batt < BATT_THRES);

  assign lft_mag_s  = sat_abs(lft_spd);
  assign rght_mag_s = sat_abs(rght_spd);
  assign mag_s      = (lft_mag_s > rght_mag_s) ? lft_mag_s : rght_mag_s;
  assign over_s     = spd_vld && (mag_s > SPD_THRES);

  // Battery persistence counter and flag next-state.
  always_comb begin
    pcnt_s     = pcnt_r;
    batt_low_s = batt_low_r;
    if (batt_vld) begin
      if (batt_qual_s) begin
        if (pcnt_r >= PERSIST_M1) begin
          batt_low_s = ~batt_low_r;
          pcnt_s     = 4'd0;
        end else begin
          pcnt_s = pcnt_r + 4'd1;
        end
      end else begin
        pcnt_s = 4'd0;
      end
    end else begin
      pcnt_s = pcnt_r;
    end
  end

  // Over-speed hold timer next-state; loss of power overrides everything.
  always_comb begin
    hold_s    = hold_r;
    ovr_spd_s = ovr_spd_r;
    if (!pwr_up) begin
      hold_s    = 24'd0;
      ovr_spd_s = 1'b0;
    end else if (over_s) begin
      hold_s    = HOLD_CYC;
      ovr_spd_s = 1'b1;
    end else if (hold_r != 24'd0) begin
      hold_s    = hold_r - 24'd1;
      ovr_spd_s = (hold_r != 24'd1);
    end else begin
      hold_s    = 24'd0;
      ovr_spd_s = 1'b0;
    end
  end

  // Rider mode FSM next-state and entry debounce counter.
  always_comb begin
    state_s = state_r;
    ecnt_s  = ecnt_r;
    if (!pwr_up) begin
      state_s = ST_OFF;
      ecnt_s  = 16'd0;
    end else begin
      case (state_r)
        ST_OFF: begin
          state_s = ST_ARMED;
          ecnt_s  = 16'd0;
        end
        ST_ARMED: begin
          if (en_steer) begin
            if (({1'b0, ecnt_r} + 17'd1) >= {1'b0, ENTRY_CYC}) begin
              state_s = ST_NORMAL;
              ecnt_s  = 16'd0;
            end else begin
              ecnt_s = ecnt_r + 16'd1;
            end
          end else begin
            ecnt_s = 16'd0;
          end
        end
        ST_NORMAL: begin
          ecnt_s = 16'd0;
          if (!en_steer) begin
            state_s = ST_ARMED;
          end else begin
            state_s = ST_NORMAL;
          end
        end
        default: begin
          state_s = ST_OFF;
          ecnt_s  = 16'd0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_OFF;
      ecnt_r      <= 16'd0;
      norm_mode_r <= 1'b0;
      pcnt_r      <= 4'd0;
      batt_low_r  <= 1'b0;
      hold_r      <= 24'd0;
      ovr_spd_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      ecnt_r      <= ecnt_s;
      norm_mode_r <= (state_s == ST_NORMAL);
      pcnt_r      <= pcnt_s;
      batt_low_r  <= batt_low_s;
      hold_r      <= hold_s;
      ovr_spd_r   <= ovr_spd_s;
    end
  end

  assign norm_mode = norm_mode_r;
  assign ovr_spd   = ovr_spd_r;
  assign batt_low  = batt_low_r;

endmodule
